program_loader: RTL and testbench
=================================

# program_loader

Boot-time instruction loader that sits directly upstream of the three-stage processor core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into instruction memory through the core's `im_WE`/`im_DATA` write port. The loader holds every core reset asserted and the pipeline registers disabled until the program is fully loaded, then releases the core to run.

## Interface
Parameters:
- `IM_DEPTH`, 256: instruction-memory capacity in words; maximum legal program length.
- `ADDR_W`, 8: width of the word address; must satisfy 2^ADDR_W >= IM_DEPTH.

Ports:
- `CLK` in 1: single clock; all state changes on the rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a load session.
- `in_valid` in 1: byte on `in_data` is valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader can accept a byte this cycle.
- `out_im_WE` out 1: instruction-memory write strobe; drives core `im_WE`.
- `out_im_ADDR` out ADDR_W: word address of the current write.
- `out_im_DATA` out 32: assembled word; drives core `im_DATA`.
- `out_core_RESET` out 1: active-high hold. Drives the core's `pc_RESET`, `rb_RESET`, `tf_RESET`, `dm_RESET`, `reg_ifid_exmem_RESET` and `reg_exmem_wb_RESET`.
- `out_pipe_ENABLE` out 1: drives `reg_ifid_exmem_ENABLE` and `reg_exmem_wb_ENABLE`.
- `out_busy` out 1: a load session is in progress.
- `out_done` out 1: program loaded and core running.
- `out_error` out 1: last session aborted on an illegal length.
- `out_count` out 16: number of words written in the current or last session.

## Operation
- A byte is accepted only on a rising edge where `in_valid && in_ready` holds.
- Stream format:
  - 2-byte length N, low byte first.
  - Then N words, 4 bytes each, least-significant byte first.

States:
- IDLE: state after reset.
  - `in_ready`=0.
  - `start` moves to LEN_LO.
- LEN_LO: `in_ready`=1; accepting a byte stores N[7:0] and moves to LEN_HI.
- LEN_HI: `in_ready`=1; accepting a byte stores N[15:8].
  - N==0 or N>IM_DEPTH: go to ERROR.
  - Otherwise: clear the word index and byte index, then go to WORD.
- WORD: `in_ready`=1.
  - Each accepted byte lands in lane byte_index (byte_index counts 0..3).
  - The 4th accepted byte moves to WRITE.
- WRITE: `in_ready`=0.
  - `out_im_WE`=1 for exactly one cycle, with `out_im_ADDR`=word index and `out_im_DATA`=assembled word.
  - On exit, word index and `out_count` increment.
  - If the new index equals N, go to RELEASE; otherwise go to WORD.
- RELEASE: one cycle with reset still held, so the core clears before running; then go to RUN.
- RUN:
  - `out_core_RESET`=0, `out_pipe_ENABLE`=1, `out_done`=1.
  - `start` returns to LEN_LO. `out_core_RESET` is reasserted and `out_pipe_ENABLE` cleared on that same edge.
- ERROR:
  - Core remains held, `out_error`=1.
  - `start` goes to LEN_LO and clears `out_error`.

General rules:
- `out_core_RESET`=1 and `out_pipe_ENABLE`=0 in every state except RUN.
- `out_busy`=1 in LEN_LO, LEN_HI, WORD, WRITE and RELEASE.
- `start` is ignored while `out_busy`=1.
- Entering LEN_LO clears `out_count` and `out_error`.
- `out_im_ADDR` and `out_im_DATA` hold their last values outside WRITE.
- N wider than ADDR_W: the comparison against IM_DEPTH uses all 16 bits. The address is the low ADDR_W bits of the index.

## Timing
- Reset values, applied immediately on RESET low:
  - State IDLE.
  - `in_ready`=0, `out_im_WE`=0, `out_im_ADDR`=0, `out_im_DATA`=0.
  - `out_core_RESET`=1, `out_pipe_ENABLE`=0.
  - `out_busy`=0, `out_done`=0, `out_error`=0, `out_count`=0.
- All outputs are registered or decoded from state. No combinational path from `in_valid` to `in_ready`.
- The cycle after the edge that accepts a word's 4th byte has `out_im_WE`=1.
- Minimum throughput: 5 cycles per word (4 bytes plus 1 write cycle).
- `out_core_RESET` falls on the 2nd rising edge after the final `out_im_WE` cycle begins (WRITE, then RELEASE).
- Gaps on `in_valid` stall the current state indefinitely; there is no timeout.
- `RESET` asserted mid-session: the session is abandoned at once. Partially written memory is not erased, and the core stays held.

## Test plan
- Reset: pulse RESET low mid-cycle -> all outputs take their reset values asynchronously; `out_core_RESET`=1.
- Two-word load: `start`, then bytes 02 00 44 33 22 11 DD CC BB AA sent back-to-back ->
  - WE at addr 0 with data 0x11223344, then WE at addr 1 with data 0xAABBCCDD.
  - `out_count`=2.
  - `out_core_RESET` falls 2 edges after the second WE; `out_done`=1 and `out_pipe_ENABLE`=1.
- Illegal length:
  - Length bytes 00 00 -> ERROR, `out_error`=1, no WE.
  - Length bytes 01 01 (257) with IM_DEPTH=256 -> ERROR.
  - A following `start` clears `out_error`.
- Backpressure: one-word load with `in_valid` low 3 cycles between every byte -> same WE data as the back-to-back case; `in_ready` drops during the WRITE cycle.
- Mid-load reset: assert RESET after 2 of 4 bytes of word 0 -> no WE, state IDLE. A fresh `start` and full load then succeed.
- Reload: `start` while in RUN -> `out_core_RESET`=1 and `out_pipe_ENABLE`=0 on that edge, `out_count`=0; a new one-word load writes addr 0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
//   Boot-time instruction loader for the three-stage core. Receives a byte
//   stream (2-byte little-endian word count N, then N little-endian 32-bit
//   words), writes each word into instruction memory, and keeps the core in
//   reset with its pipeline registers disabled until the whole program is in.
//
//   Handshake: a byte transfers on a rising edge where in_valid && in_ready.
//   in_ready is decoded from state only, so it never depends on in_valid;
//   the sender may hold in_valid low for any number of cycles.
//
// Ports
//   CLK, RESET           clock, asynchronous active-low reset
//   start                one-cycle pulse that opens a load session
//   in_valid/in_data     byte stream input, in_ready is the accept side
//   out_im_WE/ADDR/DATA  instruction-memory write port
//   out_core_RESET       active-high hold for all core resets
//   out_pipe_ENABLE      pipeline register enable
//   out_busy/done/error  session status
//   out_count            words written in the current or last session
//   dbg_state            current FSM state for observation
module program_loader #(
  parameter int IM_DEPTH = 256,
  parameter int ADDR_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_im_WE,
  output logic [ADDR_W-1:0] out_im_ADDR,
  output logic [31:0]       out_im_DATA,
  output logic              out_core_RESET,
  output logic              out_pipe_ENABLE,
  output logic              out_busy,
  output logic              out_done,
  output logic              out_error,
  output logic [15:0]       out_count,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_LO  = 3'd1,
    S_LEN_HI  = 3'd2,
    S_WORD    = 3'd3,
    S_WRITE   = 3'd4,
    S_RELEASE = 3'd5,
    S_RUN     = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t      state, next_state;
  logic [15:0] len;
  logic [15:0] count;      // doubles as the word index: both are zero when WORD is entered
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;   // lanes 0..2 of the word being assembled
  logic        accept;
  logic [15:0] len_full;
  logic        len_bad;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  assign len_full  = {in_data, len[7:0]};
  // Compare with all 16 bits so lengths above 2^ADDR_W are still rejected.
  assign len_bad   = (len_full == 16'd0) || (32'(len_full) > IM_DEPTH);
  assign last_word = ((count + 16'd1) == len);

  assign in_ready        = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_WORD);
  assign out_im_WE       = (state == S_WRITE);
  assign out_core_RESET  = (state != S_RUN);
  assign out_pipe_ENABLE = (state == S_RUN);
  assign out_done        = (state == S_RUN);
  assign out_error       = (state == S_ERROR);
  assign out_busy        = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_WORD) ||
                           (state == S_WRITE)  || (state == S_RELEASE);
  assign out_count       = count;
  assign dbg_state       = state;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_LEN_LO;
      S_LEN_LO:  if (accept) next_state = S_LEN_HI;
      S_LEN_HI:  if (accept) next_state = len_bad ? S_ERROR : S_WORD;
      S_WORD:    if (accept && (byte_idx == 2'd3)) next_state = S_WRITE;
      S_WRITE:   next_state = last_word ? S_RELEASE : S_WORD;
      S_RELEASE: next_state = S_RUN;
      S_RUN:     if (start) next_state = S_LEN_LO;
      S_ERROR:   if (start) next_state = S_LEN_LO;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      len         <= '0;
      count       <= '0;
      byte_idx    <= '0;
      word_buf    <= '0;
      out_im_ADDR <= '0;
      out_im_DATA <= '0;
    end else begin
      if ((next_state == S_LEN_LO) && (state != S_LEN_LO)) begin
        count <= '0;
      end
      if ((state == S_LEN_LO) && accept) begin
        len[7:0] <= in_data;
      end
      if ((state == S_LEN_HI) && accept) begin
        len[15:8] <= in_data;
        byte_idx  <= '0;
        count     <= '0;
      end
      if ((state == S_WORD) && accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: word_buf[7:0]   <= in_data;
          2'd1: word_buf[15:8]  <= in_data;
          2'd2: word_buf[23:16] <= in_data;
          default: begin
            // Address/data are captured here so they are valid throughout
            // the WRITE cycle and simply hold afterwards.
            out_im_DATA <= {in_data, word_buf};
            out_im_ADDR <= count[ADDR_W-1:0];
          end
        endcase
      end
      if (state == S_WRITE) begin
        count <= count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. Expected memory writes are derived from
// the byte stream itself (length parse + little-endian word assembly) and
// compared against the write port on every cycle.
module tb_program_loader;
  localparam int IM_DEPTH = 256;
  localparam int ADDR_W   = 8;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              out_im_WE;
  logic [ADDR_W-1:0] out_im_ADDR;
  logic [31:0]       out_im_DATA;
  logic              out_core_RESET;
  logic              out_pipe_ENABLE;
  logic              out_busy;
  logic              out_done;
  logic              out_error;
  logic [15:0]       out_count;
  logic [2:0]        dbg_state;

  program_loader #(.IM_DEPTH(IM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_im_WE(out_im_WE), .out_im_ADDR(out_im_ADDR),
    .out_im_DATA(out_im_DATA), .out_core_RESET(out_core_RESET),
    .out_pipe_ENABLE(out_pipe_ENABLE), .out_busy(out_busy), .out_done(out_done),
    .out_error(out_error), .out_count(out_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];   // expected {addr, data} writes, oldest first
  logic [39:0] got_log[$]; // every write seen, for literal spot checks
  int cyc = 0;
  int last_we_cyc = -100;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 40'(in_ready), 40'd0);
    check({tag, "_we"}, 40'(out_im_WE), 40'd0);
    check({tag, "_addr"}, 40'(out_im_ADDR), 40'd0);
    check({tag, "_data"}, 40'(out_im_DATA), 40'd0);
    check({tag, "_core_reset"}, 40'(out_core_RESET), 40'd1);
    check({tag, "_pipe_en"}, 40'(out_pipe_ENABLE), 40'd0);
    check({tag, "_busy"}, 40'(out_busy), 40'd0);
    check({tag, "_done"}, 40'(out_done), 40'd0);
    check({tag, "_error"}, 40'(out_error), 40'd0);
    check({tag, "_count"}, 40'(out_count), 40'd0);
    check({tag, "_state_idle"}, 40'(dbg_state), 40'd0);
  endtask

  // compare process: write port against the expected queue, run/hold coupling,
  // and the two-edge release latency after the final write
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RESET) begin
        check("core_reset_only_outside_run", 40'(out_core_RESET), 40'(!out_done));
        check("pipe_enable_only_in_run", 40'(out_pipe_ENABLE), 40'(out_done));
        if (out_im_WE) begin
          check("ready_low_during_write", 40'(in_ready), 40'd0);
          check("write_was_expected", 40'(exp_q.size() != 0), 40'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("write_addr_data", {out_im_ADDR, out_im_DATA}, e);
          end
          got_log.push_back({out_im_ADDR, out_im_DATA});
          last_we_cyc = cyc;
        end
        if (out_done && !prev_done) check("release_latency", 40'(cyc - last_we_cyc), 40'd2);
        prev_done = out_done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  // drivers
  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) @(negedge CLK);
    @(negedge CLK);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge CLK);
      t++;
    end
    check("byte_accept_timeout", 40'(t >= 100), 40'd0);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  // Runs one full session from the stream, building the expected writes
  // from the stream contents first.
  task automatic run_stream(input logic [7:0] s[$], input int gap);
    int n;
    bit legal;
    int t;
    n = int'(s[0]) + int'(s[1]) * 256;
    legal = (n != 0) && (n <= IM_DEPTH);
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        logic [31:0] w;
        w = int'(s[2 + 4*i]) + (int'(s[3 + 4*i]) << 8) +
            (int'(s[4 + 4*i]) << 16) + (int'(s[5 + 4*i]) << 24);
        exp_q.push_back({8'(i), w});
      end
    end
    pulse_start();
    check("start_busy", 40'(out_busy), 40'd1);
    check("start_core_held", 40'(out_core_RESET), 40'd1);
    check("start_pipe_off", 40'(out_pipe_ENABLE), 40'd0);
    check("start_count_cleared", 40'(out_count), 40'd0);
    check("start_error_cleared", 40'(out_error), 40'd0);
    foreach (s[i]) send_byte(s[i], gap);
    if (legal) begin
      t = 0;
      while (!out_done && t < 20) begin
        @(negedge CLK);
        t++;
      end
      check("done_timeout", 40'(t >= 20), 40'd0);
      check("end_done", 40'(out_done), 40'd1);
      check("end_count", 40'(out_count), 40'(n));
      check("end_error", 40'(out_error), 40'd0);
      check("end_busy", 40'(out_busy), 40'd0);
      check("end_pipe_en", 40'(out_pipe_ENABLE), 40'd1);
      check("end_all_writes_seen", 40'(exp_q.size()), 40'd0);
    end else begin
      @(negedge CLK);
      check("bad_len_error", 40'(out_error), 40'd1);
      check("bad_len_done", 40'(out_done), 40'd0);
      check("bad_len_busy", 40'(out_busy), 40'd0);
      check("bad_len_count", 40'(out_count), 40'd0);
      check("bad_len_core_held", 40'(out_core_RESET), 40'd1);
    end
  endtask

  initial begin
    logic [7:0] s[$];
    int nlog;
    logic [31:0] w;

    // reset state
    #2;
    check_reset_values("por");
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    // two-word back-to-back load
    s = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    run_stream(s, 0);
    nlog = got_log.size();
    check("two_word_first_literal", got_log[nlog-2], {8'h00, 32'h11223344});
    check("two_word_second_literal", got_log[nlog-1], {8'h01, 32'hAABBCCDD});
    check("two_word_count_literal", 40'(out_count), 40'd2);

    // illegal lengths, starting from RUN and then from ERROR
    s = '{8'h00, 8'h00};
    run_stream(s, 0);
    s = '{8'h01, 8'h01};
    run_stream(s, 0);
    check("no_writes_on_bad_len", 40'(got_log.size()), 40'(nlog));

    // backpressure: 3 idle cycles before every byte, leaving ERROR via start
    s = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    run_stream(s, 3);
    check("backpressure_literal", got_log[got_log.size()-1], {8'h00, 32'h11223344});

    // mid-load reset after 2 of 4 bytes of word 0
    nlog = got_log.size();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge CLK);
    RESET = 1'b1;
    check("mid_reset_no_write", 40'(got_log.size()), 40'(nlog));

    // fresh load after the abandoned session
    s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_stream(s, 1);
    check("after_reset_literal", got_log[got_log.size()-1], {8'h00, 32'hDEADBEEF});

    // reload from RUN: one word lands at address 0 again
    s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_stream(s, 0);
    check("reload_literal", got_log[got_log.size()-1], {8'h00, 32'h12345678});

    // maximum legal length: N == IM_DEPTH, last address 255
    s = '{8'h00, 8'h01};
    for (int i = 0; i < IM_DEPTH; i++) begin
      w = 32'(i) * 32'h01030507 + 32'h5A5A0000;
      s.push_back(w[7:0]);
      s.push_back(w[15:8]);
      s.push_back(w[23:16]);
      s.push_back(w[31:24]);
    end
    run_stream(s, 0);
    check("max_len_last_literal", got_log[got_log.size()-1],
          {8'hFF, 32'h5A5A0000 + 32'd255 * 32'h01030507});
    check("max_len_count_literal", 40'(out_count), 40'd256);

    repeat (3) @(negedge CLK);
    check("final_queue_empty", 40'(exp_q.size()), 40'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
